// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle between the ID stage and the hazard/forwarding controller.
// master: ID-stage side (drives instruction fields, consumes stall/forward controls).
// slave : hazard_fwd_ctrl itself.
interface hazard_fwd_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              pipe_en;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rf_we;
    logic [1:0]        id_rf_wsel;
    logic              ex_flush;
    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic [1:0]        fwd_rs1_sel;
    logic [1:0]        fwd_rs2_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;

    modport master (
        output pipe_en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_rf_wsel, ex_flush,
        input  stall_pc, stall_ifid, bubble_idex, fwd_rs1_sel, fwd_rs2_sel,
               stall_cnt, fwd_cnt
    );

    modport slave (
        input  pipe_en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_rf_wsel, ex_flush,
        output stall_pc, stall_ifid, bubble_idex, fwd_rs1_sel, fwd_rs2_sel,
               stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage miniRV pipeline.
// Tracks {valid, rd, wsel} shadows of EX/MEM/WB, drives ID operand forward
// selects (EX > MEM > WB priority), and raises load-use stalls / ID-EX bubbles.
// Optional perf counters (stall_cnt, fwd_cnt) are built when HAZARD_PERF_EN
// is defined; otherwise they are tied to zero and no counter flops exist.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input logic              cpu_clk,
    input logic              cpu_rst,
    hazard_fwd_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'b00,
        WSEL_DRAM = 2'b01,
        WSEL_PC4  = 2'b10,
        WSEL_SEXT = 2'b11
    } wsel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        wsel_e             wsel;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;

    logic  h1_ex, h1_mem, h1_wb;
    logic  h2_ex, h2_mem, h2_wb;
    fwd_e  fwd1, fwd2;
    logic  lu;
    logic  bubble;

    // WB write-back source is tracked for completeness but nothing downstream reads it
    logic  wb_wsel_unused;
    assign wb_wsel_unused = ^wb_q.wsel;

    function automatic logic hit(input stage_t s, input logic valid,
                                 input logic used, input logic [REG_AW-1:0] rs);
        return valid & used & (rs != '0) & s.v & (s.rd != '0) & (s.rd == rs);
    endfunction

    function automatic fwd_e pick(input logic he, input logic hm, input logic hw);
        if (he)      return FWD_EX;
        else if (hm) return FWD_MEM;
        else if (hw) return FWD_WB;
        else         return FWD_RF;
    endfunction

    // Hazard detection, forward selection and stall/bubble generation
    always_comb begin
        h1_ex  = hit(ex_q,  bus.id_valid, bus.id_rs1_used, bus.id_rs1);
        h1_mem = hit(mem_q, bus.id_valid, bus.id_rs1_used, bus.id_rs1);
        h1_wb  = hit(wb_q,  bus.id_valid, bus.id_rs1_used, bus.id_rs1);
        h2_ex  = hit(ex_q,  bus.id_valid, bus.id_rs2_used, bus.id_rs2);
        h2_mem = hit(mem_q, bus.id_valid, bus.id_rs2_used, bus.id_rs2);
        h2_wb  = hit(wb_q,  bus.id_valid, bus.id_rs2_used, bus.id_rs2);
        fwd1   = pick(h1_ex, h1_mem, h1_wb);
        fwd2   = pick(h2_ex, h2_mem, h2_wb);
        lu     = (h1_ex | h2_ex) & (ex_q.wsel == WSEL_DRAM);
        // flush overrides the stall: the squashed instruction need not wait
        bubble = lu | bus.ex_flush;
    end

    assign bus.stall_pc    = lu & ~bus.ex_flush;
    assign bus.stall_ifid  = lu & ~bus.ex_flush;
    assign bus.bubble_idex = bubble;
    assign bus.fwd_rs1_sel = fwd1;
    assign bus.fwd_rs2_sel = fwd2;

    // Advance the stage shadows when the pipeline moves
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (bus.pipe_en) begin
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q.v   <= bus.id_valid & bus.id_rf_we & ~bubble;
            ex_q.rd  <= bus.id_rd;
            ex_q.wsel <= wsel_e'(bus.id_rf_wsel);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    // Saturating perf counters for load-use stalls and forwarding activity
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (bus.pipe_en) begin
            if (lu && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (((fwd1 != FWD_RF) || (fwd2 != FWD_RF)) && fwd_cnt_q != '1)
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.fwd_cnt   = '0;
`endif

endmodule
